// File: rtl/enc_16_to_4_seq.sv
`default_nettype none
// ============================================================================
// Module   : enc_16_to_4_seq
// Brief    : Sequential 16-to-4 encoder. Captures a multi-hot select vector
//            and drains it into a stream of 4-bit indices, one per accepted
//            ready/valid handshake, in fixed priority order. A one-cycle done
//            pulse marks the end of each drain.
// Options  : ENC_MSB_FIRST_EN - when defined, the highest set bit is emitted
//            first (15->0); otherwise the lowest set bit comes first (0->15).
// Revision : 1.0 - initial release
// ============================================================================
module enc_16_to_4_seq (
  input  logic        clk,
  input  logic        clr,
  input  logic        load,
  input  logic [15:0] req_in,
  output logic        in_ready,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  enc_out,
  output logic [4:0]  remaining,
  output logic        done
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] mask_q, mask_d;
  logic [3:0]  enc_q, enc_d;
  logic        done_q, done_d;

  logic [15:0] w_mask_cleared;
  logic        w_handshake;

  // Index of the highest-priority set bit; 0 for an empty vector.
  function automatic logic [3:0] pri_idx(input logic [15:0] v);
    logic [3:0] idx;
    idx = 4'd0;
`ifdef ENC_MSB_FIRST_EN
    // Ascending scan: the last hit is the highest set bit.
    for (int i = 0; i < 16; i++) begin
      if (v[i]) idx = 4'(i);
    end
`else
    // Descending scan: the last hit is the lowest set bit.
    for (int i = 15; i >= 0; i--) begin
      if (v[i]) idx = 4'(i);
    end
`endif
    return idx;
  endfunction

  // Population count of the registered mask.
  function automatic logic [4:0] popcnt(input logic [15:0] v);
    logic [4:0] cnt;
    cnt = 5'd0;
    for (int i = 0; i < 16; i++) begin
      cnt = cnt + 5'(v[i]);
    end
    return cnt;
  endfunction

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == EMIT);
  assign enc_out     = enc_q;
  assign remaining   = popcnt(mask_q);
  assign done        = done_q;

  assign w_handshake    = out_valid && out_ready;
  // enc_q always names a set bit of mask_q while in EMIT, so this clears it.
  assign w_mask_cleared = mask_q & ~(16'd1 << enc_q);

  // Next-state logic: capture on load in IDLE, clear one bit per handshake in EMIT.
  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    enc_d   = enc_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (load) begin
          if (req_in != 16'd0) begin
            mask_d  = req_in;
            enc_d   = pri_idx(req_in);
            state_d = EMIT;
          end else begin
            // Empty request completes immediately; enc_out keeps its value.
            done_d = 1'b1;
          end
        end
      end
      EMIT: begin
        if (w_handshake) begin
          mask_d = w_mask_cleared;
          if (w_mask_cleared == 16'd0) begin
            // Last index accepted: hold enc_out, return to IDLE and pulse done.
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            enc_d = pri_idx(w_mask_cleared);
          end
        end
      end
      default: begin
        state_d = IDLE;
        mask_d  = 16'd0;
      end
    endcase
  end

  // State registers; clr aborts any drain without a done pulse.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= IDLE;
      mask_q  <= 16'd0;
      enc_q   <= 4'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      enc_q   <= enc_d;
      done_q  <= done_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_enc_16_to_4_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_enc_16_to_4_seq
// Brief    : Directed self-checking bench for enc_16_to_4_seq. Inputs change
//            and outputs are sampled on the falling clock edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_enc_16_to_4_seq;

  logic        clk;
  logic        clr;
  logic        load;
  logic [15:0] req_in;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  enc_out;
  logic [4:0]  remaining;
  logic        done;

  int nvec;
  int nerr;

  // Expected emission orders for the directed vectors.
  logic [3:0] exp_8421 [4];
  logic [3:0] exp_ffff [16];
  logic [3:0] exp_0009 [2];
  logic [3:0] exp_0003 [2];

  enc_16_to_4_seq dut (
    .clk       (clk),
    .clr       (clr),
    .load      (load),
    .req_in    (req_in),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .enc_out   (enc_out),
    .remaining (remaining),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one full cycle: through a rising edge to the next falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    clr = 1'b1; load = 1'b0; req_in = 16'd0; out_ready = 1'b0;
    tick();
    tick();
    nvec++; if (in_ready !== 1'b1)   begin nerr++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
    nvec++; if (out_valid !== 1'b0)  begin nerr++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    nvec++; if (enc_out !== 4'd0)    begin nerr++; $display("FAIL rst_enc_out: got %0d want 0", enc_out); end
    nvec++; if (remaining !== 5'd0)  begin nerr++; $display("FAIL rst_remaining: got %0d want 0", remaining); end
    nvec++; if (done !== 1'b0)       begin nerr++; $display("FAIL rst_done: got %b want 0", done); end
    clr = 1'b0;
    tick();
  endtask

  task automatic test_zero_load();
    load = 1'b1; req_in = 16'h0000; out_ready = 1'b1;
    tick();
    load = 1'b0;
    nvec++; if (done !== 1'b1)       begin nerr++; $display("FAIL zero_done: got %b want 1", done); end
    nvec++; if (out_valid !== 1'b0)  begin nerr++; $display("FAIL zero_valid: got %b want 0", out_valid); end
    nvec++; if (remaining !== 5'd0)  begin nerr++; $display("FAIL zero_remaining: got %0d want 0", remaining); end
    nvec++; if (in_ready !== 1'b1)   begin nerr++; $display("FAIL zero_in_ready: got %b want 1", in_ready); end
    tick();
    nvec++; if (done !== 1'b0)       begin nerr++; $display("FAIL zero_done_end: got %b want 0", done); end
    nvec++; if (out_valid !== 1'b0)  begin nerr++; $display("FAIL zero_valid_end: got %b want 0", out_valid); end
  endtask

  task automatic test_8421();
    load = 1'b1; req_in = 16'h8421; out_ready = 1'b1;
    tick();
    load = 1'b0;
    for (int k = 0; k < 4; k++) begin
      nvec++; if (out_valid !== 1'b1) begin nerr++; $display("FAIL p8421_valid[%0d]: got %b want 1", k, out_valid); end
      nvec++; if (enc_out !== exp_8421[k]) begin nerr++; $display("FAIL p8421_enc[%0d]: got %0d want %0d", k, enc_out, exp_8421[k]); end
      nvec++; if (remaining !== 5'(4 - k)) begin nerr++; $display("FAIL p8421_rem[%0d]: got %0d want %0d", k, remaining, 4 - k); end
      nvec++; if (done !== 1'b0) begin nerr++; $display("FAIL p8421_done_early[%0d]: got %b want 0", k, done); end
      tick();
    end
    nvec++; if (done !== 1'b1)       begin nerr++; $display("FAIL p8421_done: got %b want 1", done); end
    nvec++; if (in_ready !== 1'b1)   begin nerr++; $display("FAIL p8421_in_ready: got %b want 1", in_ready); end
    nvec++; if (out_valid !== 1'b0)  begin nerr++; $display("FAIL p8421_valid_end: got %b want 0", out_valid); end
    nvec++; if (enc_out !== exp_8421[3]) begin nerr++; $display("FAIL p8421_enc_hold: got %0d want %0d", enc_out, exp_8421[3]); end
    tick();
    nvec++; if (done !== 1'b0)       begin nerr++; $display("FAIL p8421_done_once: got %b want 0", done); end
  endtask

  task automatic test_ffff_backpressure();
    load = 1'b1; req_in = 16'hFFFF; out_ready = 1'b0;
    tick();
    for (int k = 0; k < 16; k++) begin
      // Stall cycle with a stray load that must be ignored.
      out_ready = 1'b0; load = 1'b1; req_in = 16'h0001;
      nvec++; if (enc_out !== exp_ffff[k]) begin nerr++; $display("FAIL ffff_enc[%0d]: got %0d want %0d", k, enc_out, exp_ffff[k]); end
      nvec++; if (remaining !== 5'(16 - k)) begin nerr++; $display("FAIL ffff_rem[%0d]: got %0d want %0d", k, remaining, 16 - k); end
      nvec++; if (in_ready !== 1'b0) begin nerr++; $display("FAIL ffff_in_ready[%0d]: got %b want 0", k, in_ready); end
      tick();
      load = 1'b0; out_ready = 1'b1;
      nvec++; if (enc_out !== exp_ffff[k]) begin nerr++; $display("FAIL ffff_hold[%0d]: got %0d want %0d", k, enc_out, exp_ffff[k]); end
      nvec++; if (remaining !== 5'(16 - k)) begin nerr++; $display("FAIL ffff_rem_hold[%0d]: got %0d want %0d", k, remaining, 16 - k); end
      nvec++; if (done !== 1'b0) begin nerr++; $display("FAIL ffff_done_early[%0d]: got %b want 0", k, done); end
      tick();
    end
    out_ready = 1'b0;
    nvec++; if (done !== 1'b1)       begin nerr++; $display("FAIL ffff_done: got %b want 1", done); end
    nvec++; if (remaining !== 5'd0)  begin nerr++; $display("FAIL ffff_rem_end: got %0d want 0", remaining); end
    tick();
    nvec++; if (done !== 1'b0)       begin nerr++; $display("FAIL ffff_done_once: got %b want 0", done); end
    nvec++; if (out_valid !== 1'b0)  begin nerr++; $display("FAIL ffff_valid_end: got %b want 0", out_valid); end
  endtask

  task automatic test_clr_abort();
    load = 1'b1; req_in = 16'h0009; out_ready = 1'b1;
    tick();
    load = 1'b0;
    nvec++; if (enc_out !== exp_0009[0]) begin nerr++; $display("FAIL abort_enc0: got %0d want %0d", enc_out, exp_0009[0]); end
    nvec++; if (remaining !== 5'd2)  begin nerr++; $display("FAIL abort_rem0: got %0d want 2", remaining); end
    tick();
    nvec++; if (enc_out !== exp_0009[1]) begin nerr++; $display("FAIL abort_enc1: got %0d want %0d", enc_out, exp_0009[1]); end
    nvec++; if (remaining !== 5'd1)  begin nerr++; $display("FAIL abort_rem1: got %0d want 1", remaining); end
    // Assert clr away from any clock edge; outputs must react immediately.
    #2 clr = 1'b1;
    #1;
    nvec++; if (out_valid !== 1'b0)  begin nerr++; $display("FAIL abort_valid: got %b want 0", out_valid); end
    nvec++; if (in_ready !== 1'b1)   begin nerr++; $display("FAIL abort_in_ready: got %b want 1", in_ready); end
    nvec++; if (enc_out !== 4'd0)    begin nerr++; $display("FAIL abort_enc: got %0d want 0", enc_out); end
    nvec++; if (remaining !== 5'd0)  begin nerr++; $display("FAIL abort_rem: got %0d want 0", remaining); end
    nvec++; if (done !== 1'b0)       begin nerr++; $display("FAIL abort_done: got %b want 0", done); end
    @(negedge clk);
    clr = 1'b0;
    tick();
    nvec++; if (done !== 1'b0)       begin nerr++; $display("FAIL abort_no_done: got %b want 0", done); end
    load = 1'b1; req_in = 16'h0002;
    tick();
    load = 1'b0;
    nvec++; if (out_valid !== 1'b1)  begin nerr++; $display("FAIL abort_new_valid: got %b want 1", out_valid); end
    nvec++; if (enc_out !== 4'd1)    begin nerr++; $display("FAIL abort_new_enc: got %0d want 1", enc_out); end
    nvec++; if (remaining !== 5'd1)  begin nerr++; $display("FAIL abort_new_rem: got %0d want 1", remaining); end
    tick();
    nvec++; if (done !== 1'b1)       begin nerr++; $display("FAIL abort_new_done: got %b want 1", done); end
    nvec++; if (enc_out !== 4'd1)    begin nerr++; $display("FAIL abort_new_hold: got %0d want 1", enc_out); end
    tick();
  endtask

  task automatic test_back_to_back();
    load = 1'b1; req_in = 16'h0001; out_ready = 1'b1;
    tick();
    load = 1'b0;
    nvec++; if (enc_out !== 4'd0)    begin nerr++; $display("FAIL b2b_enc_a: got %0d want 0", enc_out); end
    nvec++; if (remaining !== 5'd1)  begin nerr++; $display("FAIL b2b_rem_a: got %0d want 1", remaining); end
    tick();
    nvec++; if (done !== 1'b1)       begin nerr++; $display("FAIL b2b_done_a: got %b want 1", done); end
    nvec++; if (in_ready !== 1'b1)   begin nerr++; $display("FAIL b2b_in_ready: got %b want 1", in_ready); end
    // Load in the done cycle.
    load = 1'b1; req_in = 16'h0003;
    tick();
    load = 1'b0;
    nvec++; if (done !== 1'b0)       begin nerr++; $display("FAIL b2b_done_gap: got %b want 0", done); end
    nvec++; if (out_valid !== 1'b1)  begin nerr++; $display("FAIL b2b_valid_b: got %b want 1", out_valid); end
    nvec++; if (enc_out !== exp_0003[0]) begin nerr++; $display("FAIL b2b_enc_b0: got %0d want %0d", enc_out, exp_0003[0]); end
    nvec++; if (remaining !== 5'd2)  begin nerr++; $display("FAIL b2b_rem_b0: got %0d want 2", remaining); end
    tick();
    nvec++; if (enc_out !== exp_0003[1]) begin nerr++; $display("FAIL b2b_enc_b1: got %0d want %0d", enc_out, exp_0003[1]); end
    nvec++; if (remaining !== 5'd1)  begin nerr++; $display("FAIL b2b_rem_b1: got %0d want 1", remaining); end
    nvec++; if (done !== 1'b0)       begin nerr++; $display("FAIL b2b_done_early: got %b want 0", done); end
    tick();
    nvec++; if (done !== 1'b1)       begin nerr++; $display("FAIL b2b_done_b: got %b want 1", done); end
    tick();
    nvec++; if (done !== 1'b0)       begin nerr++; $display("FAIL b2b_done_once: got %b want 0", done); end
  endtask

  initial begin
    nvec = 0;
    nerr = 0;
    clr = 1'b1; load = 1'b0; req_in = 16'd0; out_ready = 1'b0;
`ifdef ENC_MSB_FIRST_EN
    exp_8421 = '{4'd15, 4'd10, 4'd5, 4'd0};
    for (int i = 0; i < 16; i++) exp_ffff[i] = 4'(15 - i);
    exp_0009 = '{4'd3, 4'd0};
    exp_0003 = '{4'd1, 4'd0};
`else
    exp_8421 = '{4'd0, 4'd5, 4'd10, 4'd15};
    for (int i = 0; i < 16; i++) exp_ffff[i] = 4'(i);
    exp_0009 = '{4'd0, 4'd3};
    exp_0003 = '{4'd0, 4'd1};
`endif
    @(negedge clk);
    test_reset();
    test_zero_load();
    test_8421();
    test_ffff_backpressure();
    test_clr_abort();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
`default_nettype wire
